sprite_blit_ctrl: RTL
=====================

Name: sprite_blit_ctrl

Overview:
- Sequencer that copies one 40x40 sprite from the sprite ROM into the 160x120 frame buffer or VGA adapter, with its top-left corner at a requested screen position.
- Generates the 11-bit sprite ROM address and the matching screen x/y, colour and plot strobe.
- Sits directly downstream of the game-logic/sprite-address stage and upstream of the VGA adapter.
- Skips transparent pixels and clips pixels that fall off-screen.

Parameters:
- SPRITE_W, 40, sprite width in pixels
- SPRITE_H, 40, sprite height in pixels
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- COLOUR_W, 3, colour bits per pixel
- TRANSPARENT, 3'b000, colour value that is never plotted

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin blit; sampled only in IDLE
- pos_x  in  8  sprite top-left x (0..159); latched on accepted start
- pos_y  in  7  sprite top-left y (0..119); latched on accepted start
- sprite_addr  out  11  ROM address, row-major: row*SPRITE_W+col
- sprite_data  in  COLOUR_W  ROM read data, valid the cycle after its address (synchronous ROM)
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  COLOUR_W  pixel colour
- vga_plot  out  1  write enable for vga_x/vga_y/vga_colour
- busy  out  1  high while a blit is in progress
- done  out  1  one-cycle pulse when the blit completes

Behaviour:
- Reset (async, resetn=0): state=IDLE; all outputs 0; col/row counters 0; pipeline valid=0. Takes effect immediately, including mid-blit. No partial resume after reset.
- States: IDLE, DRAW, FLUSH, DONE.
- IDLE:
  - start=1 at edge T → latch pos_x/pos_y, clear col/row, go to DRAW.
  - busy=1 from T+1.
- DRAW:
  - Each cycle drive sprite_addr=row*SPRITE_W+col, then advance col.
  - At col=SPRITE_W-1: col wraps to 0 and row increments.
  - Address k is issued in cycle T+1+k, for k=0..1599.
  - After address 1599 is issued → FLUSH.
- Pipeline:
  - One register stage holds {valid, px=pos_x+col, py=pos_y+row} for the address issued last cycle.
  - px and py are computed 8 bits wide and never truncated before clipping.
- Output generation (combinational from the pipeline stage and sprite_data):
  - vga_x=px[7:0], vga_y=py[6:0], vga_colour=sprite_data.
  - vga_plot = valid AND sprite_data≠TRANSPARENT AND px<SCREEN_W AND py<SCREEN_H.
- Latency: pixel k is presented in cycle T+2+k; the last pixel (k=1599) appears in cycle T+1601, the FLUSH cycle.
- FLUSH: no new address; sprite_addr holds 1599. Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle (T+1602), then IDLE.
- start behaviour:
  - Ignored in DRAW, FLUSH and DONE.
  - start asserted in the cycle after DONE (back in IDLE) is accepted.
- Position inputs: pos_x/pos_y changes during a blit have no effect.
- Counter arithmetic: unsigned; col is 6 bits, row is 6 bits; sprite_addr is computed without overflow (max 1599 < 2048).
- vga_plot is 0 in IDLE, in DONE, and in the first DRAW cycle.

Decomposition:
- Shared package (game_pkg) holds:
  - Screen and sprite dimension constants (160, 120, 40, 40).
  - COLOUR_W and the TRANSPARENT colour.
  - The blit state enum {IDLE, DRAW, FLUSH, DONE}.
- One sub-module, sprite_xy_counter:
  - col/row counter with wrap at SPRITE_W and SPRITE_H.
  - Enable and clear inputs; outputs col, row, linear address and a last flag (col=39, row=39).

Test Plan:
- Full opaque blit: ROM all 3'b101, start at (0,0) → 1600 plots; first plot (0,0) at T+2; last plot (39,39) at T+1601; done pulse at T+1602; busy high T+1..T+1601.
- Clipping: start at (150,100), ROM all opaque → exactly 200 plots (cols 0..9, rows 0..19); no plot with x≥160 or y≥120; done still at T+1602.
- Transparency: ROM is a checkerboard of 3'b000/3'b111, start at (10,10) → 800 plots, all colour 3'b111; the plot at (10,10) absent and at (11,10) present; the address sequence is still 0..1599.
- start pulses during busy: extra start at T+5 and T+1601 → exactly one blit, one done pulse; pos changes mid-blit leave all vga_x/vga_y unchanged.
- Reset mid-blit: resetn=0 at T+700 → all outputs 0 in the same cycle, state IDLE; a new start after release gives a complete, correct 1600-pixel blit.
- Back-to-back: start in the cycle after done → second blit begins with sprite_addr=0; no missed or duplicated pixels across the two blits.

Source files
------------

// File: rtl/game_pkg.sv
// Shared screen/sprite geometry, colour encoding and blit state type for the sprite path.
package game_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned SPRITE_W = 40;
    localparam int unsigned SPRITE_H = 40;

    localparam int unsigned COLOUR_W = 3;
    localparam logic [COLOUR_W-1:0] TRANSPARENT = 3'b000;

    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned ROW_W  = 6;
    localparam int unsigned ADDR_W = 11;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StFlush,
        StDone
    } blit_state_e;

    // row*40 + col via shifts; max 39*40+39 = 1599 fits in 11 bits.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        logic [ADDR_W-1:0] w_row;
        w_row    = {5'd0, row};
        lin_addr = (w_row << 5) + (w_row << 3) + {5'd0, col};
    endfunction

endpackage

// File: rtl/sprite_blit_ctrl_if.sv
// Bus bundle between the sprite sequencer, its ROM, the upstream game logic and the VGA adapter.
interface sprite_blit_ctrl_if;
    import game_pkg::*;

    logic                start;
    logic [X_W-1:0]      pos_x;
    logic [Y_W-1:0]      pos_y;
    logic [ADDR_W-1:0]   sprite_addr;
    logic [COLOUR_W-1:0] sprite_data;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                busy;
    logic                done;

    modport master (
        output start, pos_x, pos_y, sprite_data,
        input  sprite_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  start, pos_x, pos_y, sprite_data,
        output sprite_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

endinterface

// File: rtl/sprite_blit_ctrl_xy_counter.sv
// Row-major col/row walker over the sprite, producing the linear ROM address and a last flag.
module sprite_xy_counter
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_en,
    input  logic              i_clr,
    output logic [COL_W-1:0]  o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_col_end;
    logic             w_row_end;

    assign w_col_end = (r_col == COL_W'(SPRITE_W - 1));
    assign w_row_end = (r_row == ROW_W'(SPRITE_H - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_addr = lin_addr(r_row, r_col);
    assign o_last = w_col_end && w_row_end;

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Sequencer copying one 40x40 sprite from a synchronous ROM to the screen, skipping
// transparent pixels and clipping anything that lands outside 160x120.
module sprite_blit_ctrl
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    sprite_blit_ctrl_if.slave io_bus
);

    blit_state_e      r_state;
    blit_state_e      w_state_next;
    logic [X_W-1:0]   r_pos_x;
    logic [Y_W-1:0]   r_pos_y;
    logic             r_valid;
    logic [7:0]       r_px;
    logic [7:0]       r_py;

    logic             w_accept;
    logic             w_cnt_en;
    logic             w_cnt_clr;
    logic             w_last;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [ADDR_W-1:0] w_addr;
    logic             w_opaque;
    logic             w_on_screen;

    sprite_xy_counter u_xy_counter (
        .clk    (clk),
        .resetn (resetn),
        .i_en   (w_cnt_en),
        .i_clr  (w_cnt_clr),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counter stops on the last address so FLUSH keeps presenting 1599.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cnt_en     = 1'b0;
        w_cnt_clr    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    w_accept     = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = StDraw;
                end
            end
            StDraw: begin
                w_cnt_en = !w_last;
                if (w_last) begin
                    w_state_next = StFlush;
                end
            end
            StFlush: w_state_next = StDone;
            StDone: begin
                w_cnt_clr    = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Screen coordinates are kept 8 bits wide so off-screen pixels compare correctly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_valid <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
        end else begin
            if (w_accept) begin
                r_pos_x <= io_bus.pos_x;
                r_pos_y <= io_bus.pos_y;
            end
            r_valid <= (r_state == StDraw);
            if (r_state == StDraw) begin
                r_px <= r_pos_x + {2'd0, w_col};
                r_py <= {1'b0, r_pos_y} + {2'd0, w_row};
            end
        end
    end

    assign w_opaque    = (io_bus.sprite_data != TRANSPARENT);
    assign w_on_screen = (r_px < 8'(SCREEN_W)) && (r_py < 8'(SCREEN_H));

    assign io_bus.sprite_addr = w_addr;
    assign io_bus.vga_x       = r_px;
    assign io_bus.vga_y       = r_py[Y_W-1:0];
    // Colour is forced to zero outside valid pixels so reset clears every output.
    assign io_bus.vga_colour  = r_valid ? io_bus.sprite_data : '0;
    assign io_bus.vga_plot    = r_valid && w_opaque && w_on_screen;
    assign io_bus.busy        = (r_state == StDraw) || (r_state == StFlush);
    assign io_bus.done        = (r_state == StDone);

endmodule
